// File: rtl/fsm_pkg.sv
// Shared widths, reset values and default timing constants for the
// virtual-pet needs controller.
package fsm_pkg;

  localparam int LVL_W = 3;

  typedef logic [LVL_W-1:0] lvl_t;

  localparam lvl_t LVL_MAX = 3'd7;

  // Reset levels: needs start comfortably full, energy starts mid-range.
  localparam lvl_t NH_RST = 3'd5;
  localparam lvl_t NS_RST = 3'd5;
  localparam lvl_t NF_RST = 3'd5;
  localparam lvl_t NE_RST = 3'd3;

  // Default time base and action timing.
  localparam int TICK_NORMAL_DEF = 50_000_000;
  localparam int TICK_ACC_DEF    = 50;
  localparam int DECAY_DIV_DEF   = 4;
  localparam int REPEAT_DEF      = 40;

  // Energy decision taken on every time tick.
  typedef enum logic [1:0] {
    EN_HOLD = 2'd0,
    EN_UP   = 2'd1,
    EN_DOWN = 2'd2
  } energy_e;

endpackage

// File: rtl/fsmcontrol_core_action_pulse.sv
// Turns one asynchronous action button into single-cycle action pulses:
// two-flop synchronizer, rising-edge detect, and auto-repeat every REPEAT
// cycles while the button stays held.
module action_pulse
  import fsm_pkg::*;
#(
  parameter int REPEAT = REPEAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic fire
);

  localparam int CNT_W = (REPEAT > 2) ? $clog2(REPEAT) : 1;

  logic             in_p0;
  logic             in_p1;
  logic             in_p2;
  logic [CNT_W-1:0] hold_cnt;
  logic             rise;
  logic             rep;

  // in_p1 is the synchronized level; in_p2 is its previous value.
  assign rise = in_p1 & ~in_p2;
  assign rep  = in_p1 & in_p2 & (hold_cnt == CNT_W'(REPEAT - 1));
  assign fire = rise | rep;

  // Synchronizer, edge history and hold-time counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_p0    <= 1'b0;
      in_p1    <= 1'b0;
      in_p2    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      in_p0 <= in;
      in_p1 <= in_p0;
      in_p2 <= in_p1;
      if (!in_p1 || fire) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsmcontrol_core.sv
// Needs/state controller for the virtual pet. Keeps four saturating 3-bit
// levels (NH hunger-satisfaction, NS affection, NF fun, NE energy), raises
// or lowers them on user actions, decays the needs on a slow time base and
// regulates energy from how well the needs are met.
module fsmcontrol_core
  import fsm_pkg::*;
#(
  parameter int TICK_NORMAL = TICK_NORMAL_DEF,
  parameter int TICK_ACC    = TICK_ACC_DEF,
  parameter int DECAY_DIV   = DECAY_DIV_DEF,
  parameter int REPEAT      = REPEAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sound,
  input  logic             d,
  input  logic             sting,
  input  logic             food,
  input  logic             acc,
  output logic [LVL_W-1:0] NH,
  output logic [LVL_W-1:0] NS,
  output logic [LVL_W-1:0] NF,
  output logic [LVL_W-1:0] NE
);

  localparam int TICK_MAXV = (TICK_NORMAL > TICK_ACC) ? TICK_NORMAL : TICK_ACC;
  localparam int TW        = $clog2(TICK_MAXV + 1);
  localparam int DW        = $clog2(DECAY_DIV + 1);
  localparam int SW        = LVL_W + 2;

  typedef logic signed [SW-1:0] sum_t;
  typedef logic signed [2:0]    delta_t;

  // Clamp a signed intermediate sum into 0..LVL_MAX.
  function automatic lvl_t sat(input sum_t v);
    if (v < sum_t'(0)) begin
      return '0;
    end else if (v > sum_t'({2'b00, LVL_MAX})) begin
      return LVL_MAX;
    end else begin
      return v[LVL_W-1:0];
    end
  endfunction

  // Net change from one raising cause and up to two lowering causes.
  function automatic delta_t net_delta(input logic up, input logic dn_a,
                                       input logic dn_b);
    delta_t dl;
    dl = 3'sd0;
    if (up)   dl = dl + 3'sd1;
    if (dn_a) dl = dl - 3'sd1;
    if (dn_b) dl = dl - 3'sd1;
    return dl;
  endfunction

  // Apply a net change to a level, then saturate once.
  function automatic lvl_t apply(input lvl_t lvl, input delta_t dl);
    sum_t s;
    s = sum_t'({2'b00, lvl}) + sum_t'(dl);
    return sat(s);
  endfunction

  logic          food_fire;
  logic          sting_fire;
  logic          sound_fire;
  logic          d_fire;

  logic          acc_q;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_lim;
  logic          tick;
  logic [DW-1:0] div_cnt;
  logic          decay;

  lvl_t          nh_n;
  lvl_t          ns_n;
  lvl_t          nf_n;
  lvl_t          ne_n;
  energy_e       en_mode;

  action_pulse #(.REPEAT(REPEAT)) u_food  (.clk(clk), .rst(rst), .in(food),  .fire(food_fire));
  action_pulse #(.REPEAT(REPEAT)) u_sting (.clk(clk), .rst(rst), .in(sting), .fire(sting_fire));
  action_pulse #(.REPEAT(REPEAT)) u_sound (.clk(clk), .rst(rst), .in(sound), .fire(sound_fire));
  action_pulse #(.REPEAT(REPEAT)) u_d     (.clk(clk), .rst(rst), .in(d),     .fire(d_fire));

  // A tick is suppressed in the cycle where acc changes; the count restarts.
  assign tick_lim = acc_q ? TW'(TICK_ACC - 1) : TW'(TICK_NORMAL - 1);
  assign tick     = (acc == acc_q) && (tick_cnt == tick_lim);
  assign decay    = tick && (div_cnt == DW'(DECAY_DIV - 1));

  // Time base: restart on mode change, wrap and tick at the selected period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= 1'b0;
      tick_cnt <= '0;
    end else if (acc != acc_q) begin
      acc_q    <= acc;
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Decay divider: one decay step every DECAY_DIV ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      if (decay) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Next levels: needs first, then energy judged on the updated needs.
  always_comb begin
    nh_n    = apply(NH, net_delta(food_fire,  decay, 1'b0));
    ns_n    = apply(NS, net_delta(sting_fire, decay, 1'b0));
    nf_n    = apply(NF, net_delta(sound_fire, decay, 1'b0));
    en_mode = EN_HOLD;
    if (tick) begin
      if ((nh_n >= 3'd3) && (ns_n >= 3'd3) && (nf_n >= 3'd3)) begin
        en_mode = EN_UP;
      end else if ((nh_n == '0) || (ns_n == '0) || (nf_n == '0)) begin
        en_mode = EN_DOWN;
      end
    end
    ne_n = apply(NE, net_delta(en_mode == EN_UP, d_fire, en_mode == EN_DOWN));
  end

  // Level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      NH <= NH_RST;
      NS <= NS_RST;
      NF <= NF_RST;
      NE <= NE_RST;
    end else begin
      NH <= nh_n;
      NS <= ns_n;
      NF <= nf_n;
      NE <= ne_n;
    end
  end

endmodule

// File: tb/tb_fsmcontrol_core.sv
// Bench for fsmcontrol_core: directed scenarios plus a random phase, every
// cycle compared against a cycle-level behavioural model of the pet rules.
module tb_fsmcontrol_core;

  localparam int TN = 50_000_000;
  localparam int TA = 50;
  localparam int DD = 4;
  localparam int RP = 40;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       sound = 1'b0;
  logic       d     = 1'b0;
  logic       sting = 1'b0;
  logic       food  = 1'b0;
  logic       acc   = 1'b0;
  logic [2:0] NH;
  logic [2:0] NS;
  logic [2:0] NF;
  logic [2:0] NE;

  int errors = 0;
  int checks = 0;

  // Model state: levels NH,NS,NF,NE; input history two edges deep;
  // run length of the synchronized level; time base phase and decay count.
  int mlvl[4];
  bit p1[4];
  bit p2[4];
  int run[4];
  bit acc_prev;
  int phase;
  int dcount;

  always #5 clk = ~clk;

  fsmcontrol_core #(
    .TICK_NORMAL(TN),
    .TICK_ACC(TA),
    .DECAY_DIV(DD),
    .REPEAT(RP)
  ) dut (
    .clk(clk), .rst(rst), .sound(sound), .d(d), .sting(sting), .food(food),
    .acc(acc), .NH(NH), .NS(NS), .NF(NF), .NE(NE)
  );

  function automatic int clampv(input int v);
    if (v < 0) return 0;
    if (v > 7) return 7;
    return v;
  endfunction

  task automatic model_reset();
    mlvl = '{5, 5, 5, 3};
    for (int i = 0; i < 4; i++) begin
      p1[i]  = 1'b0;
      p2[i]  = 1'b0;
      run[i] = 0;
    end
    acc_prev = 1'b0;
    phase    = 0;
    dcount   = 0;
  endtask

  // One clock edge of the pet rules: an input level seen two edges ago acts
  // now; it acts on the first cycle of a run and every RP cycles after.
  task automatic model_edge();
    bit cur[4];
    int fire[4];
    bit tick;
    int dec;
    int e;
    cur = '{food, sting, sound, d};
    for (int i = 0; i < 4; i++) begin
      run[i]  = p2[i] ? run[i] + 1 : 0;
      fire[i] = (p2[i] && ((run[i] - 1) % RP == 0)) ? 1 : 0;
      p2[i]   = p1[i];
      p1[i]   = cur[i];
    end
    tick = 1'b0;
    if (acc !== acc_prev) begin
      acc_prev = acc;
      phase    = 0;
    end else begin
      phase++;
      tick = ((phase % (acc_prev ? TA : TN)) == 0);
    end
    dec = 0;
    if (tick) begin
      dcount++;
      if (dcount == DD) begin
        dec    = 1;
        dcount = 0;
      end
    end
    for (int i = 0; i < 3; i++) mlvl[i] = clampv(mlvl[i] + fire[i] - dec);
    e = 0;
    if (tick) begin
      if (mlvl[0] >= 3 && mlvl[1] >= 3 && mlvl[2] >= 3) e = 1;
      else if (mlvl[0] == 0 || mlvl[1] == 0 || mlvl[2] == 0) e = -1;
    end
    mlvl[3] = clampv(mlvl[3] + e - fire[3]);
  endtask

  task automatic check(input string tag, input int h, input int s,
                       input int f, input int e);
    logic [11:0] exp;
    exp = {3'(h), 3'(s), 3'(f), 3'(e)};
    checks++;
    assert ({NH, NS, NF, NE} === exp) else begin
      errors++;
      $error("FAIL %s: observed NH/NS/NF/NE=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
             tag, NH, NS, NF, NE, h, s, f, e);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check(tag, mlvl[0], mlvl[1], mlvl[2], mlvl[3]);
  endtask

  task automatic run_n(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 check("reset_async", 5, 5, 5, 3);
    run_n(2, "reset_hold");
    rst = 1'b0;
    check("reset_state", 5, 5, 5, 3);

    run_n(2000, "idle_normal");
    check("idle_no_change", 5, 5, 5, 3);

    acc = 1'b1;
    run_n(300, "acc_ramp");
    check("acc_energy_sat", 4, 4, 4, 7);

    acc  = 1'b0;
    food = 1'b1;
    run_n(30, "food_pulse");
    food = 1'b0;
    run_n(20, "food_pulse_idle");
    check("food_once", 5, 4, 4, 7);

    food = 1'b1;
    run_n(60, "food_hold");
    food = 1'b0;
    run_n(20, "food_hold_idle");
    check("food_repeat", 7, 4, 4, 7);

    sting = 1'b1;
    run_n(2, "sting_lat");
    check("sting_edge2", 7, 4, 4, 7);
    step("sting_lat");
    check("sting_edge3", 7, 5, 4, 7);
    run_n(2, "sting_pulse");
    sting = 1'b0;
    run_n(10, "sting_idle");

    sound = 1'b1;
    run_n(100, "sound_hold");
    sound = 1'b0;
    run_n(10, "sound_idle");
    check("sound_sat", 7, 5, 7, 7);

    d = 1'b1;
    run_n(100, "d_hold");
    d = 1'b0;
    run_n(10, "d_idle");
    check("d_drain", 7, 5, 7, 4);

    food = 1'b1;
    run_n(10, "food_at_max");
    food = 1'b0;
    run_n(10, "food_at_max_idle");
    check("food_sat", 7, 5, 7, 4);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(29) == 0) food  = ~food;
      if ($urandom_range(29) == 0) sting = ~sting;
      if ($urandom_range(29) == 0) sound = ~sound;
      if ($urandom_range(29) == 0) d     = ~d;
      if ($urandom_range(399) == 0) acc  = ~acc;
      step("random");
    end
    food  = 1'b0;
    sting = 1'b0;
    sound = 1'b0;
    d     = 1'b0;

    acc = 1'b1;
    run_n(3000, "decay");
    check("decay_empty", 0, 0, 0, 0);
    run_n(500, "decay_floor");
    check("no_wrap", 0, 0, 0, 0);

    acc  = 1'b0;
    food = 1'b1;
    run_n(10, "food_before_rst");
    check("food_from_empty", 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 check("rst_mid_hold", 5, 5, 5, 3);
    food = 1'b0;
    run_n(2, "rst_hold2");
    rst = 1'b0;
    run_n(50, "post_rst");
    check("no_spurious", 5, 5, 5, 3);
    food = 1'b1;
    run_n(5, "new_edge");
    food = 1'b0;
    run_n(10, "new_edge_idle");
    check("new_edge_fires", 6, 5, 5, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsmcontrol_core.md
Name: fsmcontrol_core

Overview:
- Needs/state controller for a virtual-pet system.
- Tracks four 3-bit need levels: hunger-satisfaction NH, affection NS, fun NF and energy NE.
- User inputs (food, sting/pet, sound, d = physical activity) raise or lower levels.
- An internal time base decays the needs and regulates energy. acc selects an accelerated time base for demo/test.
- Sits between the input conditioning logic and the display/animation logic.

Parameters:
- TICK_NORMAL, 50_000_000, clock cycles per time tick in normal mode.
- TICK_ACC, 50, clock cycles per time tick when acc=1.
- DECAY_DIV, 4, time ticks per decay step of NH/NS/NF.
- REPEAT, 40, auto-repeat period in cycles while an action input is held.
- LVL_MAX, 7, saturation ceiling.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sound  in  1  sound/play stimulus; raises NF
- d  in  1  physical activity; drains NE
- sting  in  1  petting; raises NS
- food  in  1  feeding; raises NH
- acc  in  1  1 = accelerated time base
- NH  out  3  hunger-satisfaction level 0..7
- NS  out  3  affection level 0..7
- NF  out  3  fun level 0..7
- NE  out  3  energy level 0..7

Behaviour:
- One clock domain. Reset is asynchronous and active-high on rst.
- Reset values: NH=NS=NF=5, NE=3. Tick counter, decay divider, repeat counters and synchronizers all clear to 0.
- Input conditioning:
  - Each of sound, d, sting and food passes through a 2-flop synchronizer, then rising-edge detection.
  - An action fires on the synchronized rising edge.
  - While the input stays high, the action fires again every REPEAT cycles.
  - Latency: the level changes at the 3rd rising clk edge after the input rises.
- Actions, all saturating:
  - food: NH+1 (max 7).
  - sting: NS+1.
  - sound: NF+1.
  - d: NE-1 (min 0).
- Time base:
  - Counter compares against TICK_ACC if acc=1, else TICK_NORMAL, and emits a 1-cycle tick.
  - When acc changes, the counter restarts from 0.
- Decay: every DECAY_DIV ticks, NH, NS and NF each decrement by 1, saturating at 0.
- Energy, evaluated on every tick after that tick's decay:
  - If NH, NS and NF are all ≥3: NE+1 (saturating).
  - Else if any of them is 0: NE-1 (saturating).
  - Otherwise NE holds.
- Simultaneous events on the same level in the same cycle: apply the user action and the time effect as a net sum, then saturate. Example: food +1 and decay -1 gives no change.
- No wrap-around anywhere: 7 stays 7 on increment, 0 stays 0 on decrement.
- Reset mid-operation: all state returns to reset values immediately, without waiting for clk.

Decomposition:
- Package fsm_pkg holds:
  - LVL_W=3 and LVL_MAX=7.
  - Reset constants NH_RST=5, NS_RST=5, NF_RST=5, NE_RST=3.
  - Default tick, DECAY_DIV and REPEAT values.
- Sub-module action_pulse:
  - Contains the synchronizer, edge detect and REPEAT auto-repeat.
  - Instantiated four times.
- Saturating update logic stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles → NH=NS=NF=5, NE=3. Hold rst low with no inputs for 2000 cycles in normal mode → no change.
- Accelerated time: acc=1 for 300 cycles → NE rises to 7 (saturates) while needs stay ≥3. With TICK_ACC=50, NH/NS/NF are 4 after tick 4.
- Food: a 30-cycle pulse → NH +1 exactly once. A 60-cycle hold → +2 (edge plus one repeat). Sting 5-cycle pulse → NS +1 at the 3rd clk edge after the rise.
- Sound and activity: sound held 100 cycles → NF +3 (saturating at 7). d held 100 cycles → NE -3 (floor 0).
- Decay to empty: acc=1 for 3000 cycles, no actions → NH=NS=NF=0 and then NE=0. No wrap to 7 afterwards.
- Saturation and async reset: at NH=7 a food pulse leaves NH=7. Asserting rst mid-hold of food restores reset values within the same cycle. After release, no spurious action fires unless food makes a new rising edge.
